// File: rtl/mini16_reset_sequencer_if.sv
// Reset sequencer boundary: qualification inputs in, per-domain resets and status out.
// The sequencer uses the master modport; the SoC top / test environment uses slave.
interface mini16_reset_sequencer_if #(
   parameter int CHANNELS = 4
);
   logic                pll_locked;
   logic                button_n;
   logic                sw_reset_req;
   logic [CHANNELS-1:0] reset_out;
   logic                ready;
   logic [7:0]          restart_count;

   modport master (
      input  pll_locked, button_n, sw_reset_req,
      output reset_out, ready, restart_count
   );

   modport slave (
      output pll_locked, button_n, sw_reset_req,
      input  reset_out, ready, restart_count
   );
endinterface

// File: rtl/mini16_reset_sequencer.sv
// Qualifies PLL lock, a debounced push button and a software request, holds all
// resets for HOLD_CYCLES, then releases CHANNELS resets one per STAGE_DELAY cycles.
module mini16_reset_sequencer #(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int HOLD_CYCLES     = 16,
   parameter int STAGE_DELAY     = 256
) (
   input logic                      clk,
   input logic                      reset_n,
   mini16_reset_sequencer_if.master bus
);

   localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
   localparam int STAGE_W = $clog2(STAGE_DELAY) + 1;
   localparam int IDX_W   = $clog2(CHANNELS) + 1;

   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_DELAY - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(CHANNELS - 1);

   typedef enum logic [1:0] {
      ST_ASSERT = 2'd0,
      ST_SEQ    = 2'd1,
      ST_RUN    = 2'd2
   } state_e;

   logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
   logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
   logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
   logic                   pressed_q, pressed_d;
   state_e                 state_q, state_d;
   logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic [STAGE_W-1:0]     stage_cnt_q, stage_cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CHANNELS-1:0]    reset_out_q, reset_out_d;
   logic                   ready_q, ready_d;
   logic [7:0]             restart_q, restart_d;

   logic lock_s, btn_s, abort;

   assign lock_s = lock_sync_q[SYNC_STAGES-1];
   assign btn_s  = btn_sync_q[SYNC_STAGES-1];
   assign abort  = ~lock_s | pressed_q | bus.sw_reset_req;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], bus.pll_locked};
      btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], bus.button_n};

      // btn_s is active-low, so equality with pressed_q means the two disagree.
      deb_cnt_d = '0;
      pressed_d = pressed_q;
      if (btn_s == pressed_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            pressed_d = ~pressed_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end

      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      stage_cnt_d = stage_cnt_q;
      idx_d       = idx_q;
      reset_out_d = reset_out_q;
      ready_d     = ready_q;
      restart_d   = restart_q;

      if (abort && (state_q != ST_ASSERT)) begin
         state_d     = ST_ASSERT;
         hold_cnt_d  = '0;
         stage_cnt_d = '0;
         idx_d       = '0;
         reset_out_d = '1;
         ready_d     = 1'b0;
         if (restart_q != 8'hFF) restart_d = restart_q + 8'd1;
      end else begin
         unique case (state_q)
            ST_ASSERT: begin
               reset_out_d = '1;
               ready_d     = 1'b0;
               if (abort) begin
                  hold_cnt_d = '0;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  state_d     = ST_SEQ;
                  hold_cnt_d  = '0;
                  stage_cnt_d = '0;
                  idx_d       = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            ST_SEQ: begin
               if (stage_cnt_q == STAGE_LAST) begin
                  stage_cnt_d = '0;
                  idx_d       = idx_q + 1'b1;
                  for (int i = 0; i < CHANNELS; i++) begin
                     if (idx_q == IDX_W'(i)) reset_out_d[i] = 1'b0;
                  end
                  if (idx_q == IDX_LAST) begin
                     state_d     = ST_RUN;
                     ready_d     = 1'b1;
                     reset_out_d = '0;
                  end
               end else begin
                  stage_cnt_d = stage_cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               reset_out_d = '0;
               ready_d     = 1'b1;
            end
            default: begin
               state_d     = ST_ASSERT;
               reset_out_d = '1;
               ready_d     = 1'b0;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_sync_q <= '0;
         btn_sync_q  <= '1;
         deb_cnt_q   <= '0;
         pressed_q   <= 1'b0;
         state_q     <= ST_ASSERT;
         hold_cnt_q  <= '0;
         stage_cnt_q <= '0;
         idx_q       <= '0;
         reset_out_q <= '1;
         ready_q     <= 1'b0;
         restart_q   <= '0;
      end else begin
         lock_sync_q <= lock_sync_d;
         btn_sync_q  <= btn_sync_d;
         deb_cnt_q   <= deb_cnt_d;
         pressed_q   <= pressed_d;
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         stage_cnt_q <= stage_cnt_d;
         idx_q       <= idx_d;
         reset_out_q <= reset_out_d;
         ready_q     <= ready_d;
         restart_q   <= restart_d;
      end
   end

   assign bus.reset_out     = reset_out_q;
   assign bus.ready         = ready_q;
   assign bus.restart_count = restart_q;

endmodule

// File: tb/tb_mini16_reset_sequencer.sv
// Bench for mini16_reset_sequencer: directed scenarios plus random lock/button/request
// traffic, all compared each cycle against a qualified-cycle-count reference model.
module tb_mini16_reset_sequencer;

   localparam int CH   = 4;
   localparam int SYNC = 2;
   localparam int DB   = 32;
   localparam int HOLD = 16;
   localparam int SD   = 8;
   localparam int QMAX = HOLD + CH * SD;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mini16_reset_sequencer_if #(.CHANNELS(CH)) bus ();

   mini16_reset_sequencer #(
      .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
      .HOLD_CYCLES(HOLD), .STAGE_DELAY(SD)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: qual = consecutive abort-free cycles since the last abort.
   // The whole reset schedule follows arithmetically from that one number.
   int qual;
   int restarts;
   bit m_pressed;
   bit lock_pipe[$];
   bit btn_pipe[$];
   bit btn_hist[$];

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
         $error("check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(string tag);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at %0t", tag, $time);
   endtask

   function automatic int released();
      int n;
      if (qual < HOLD) return 0;
      n = (qual - HOLD) / SD;
      return (n > CH) ? CH : n;
   endfunction

   function automatic logic [CH-1:0] exp_out();
      logic [CH-1:0] v;
      v = '1;
      for (int k = 0; k < released(); k++) v[k] = 1'b0;
      return v;
   endfunction

   task automatic model_reset();
      qual      = 0;
      restarts  = 0;
      m_pressed = 1'b0;
      lock_pipe.delete();
      btn_pipe.delete();
      btn_hist.delete();
      for (int i = 0; i < SYNC; i++) begin
         lock_pipe.push_back(1'b0);
         btn_pipe.push_back(1'b1);
      end
   endtask

   task automatic model_edge();
      bit lock_s, btn_s, abort, all_same;
      lock_s = lock_pipe[0];
      btn_s  = btn_pipe[0];
      abort  = !lock_s || m_pressed || (bus.sw_reset_req === 1'b1);
      if (abort) begin
         if (qual >= HOLD && restarts < 255) restarts++;
         qual = 0;
      end else if (qual < QMAX) begin
         qual++;
      end
      // pressed flips once the last DB synchronised samples all show the opposite level
      btn_hist.push_back(btn_s);
      if (btn_hist.size() > DB) void'(btn_hist.pop_front());
      if (btn_hist.size() == DB) begin
         all_same = 1'b1;
         foreach (btn_hist[i]) if (btn_hist[i] != m_pressed) all_same = 1'b0;
         if (all_same) begin
            m_pressed = !m_pressed;
            btn_hist.delete();
         end
      end
      void'(lock_pipe.pop_front());
      lock_pipe.push_back(bus.pll_locked);
      void'(btn_pipe.pop_front());
      btn_pipe.push_back(bus.button_n);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (reset_n) model_edge();
      else model_reset();
      @(negedge clk);
      check("reset_out", bus.reset_out, exp_out());
      check("ready", bus.ready, (released() == CH) ? 1 : 0);
      check("restart_count", bus.restart_count, restarts);
   endtask

   task automatic wait_released(int n, int limit, string tag);
      int k = 0;
      while (released() != n && k < limit) begin
         cycle();
         k++;
      end
      if (released() != n) timeout(tag);
   endtask

   task automatic pulse_sw();
      bus.sw_reset_req = 1'b1;
      cycle();
      bus.sw_reset_req = 1'b0;
   endtask

   initial begin
      int len, kind, k;
      reset_n          = 1'b0;
      bus.pll_locked   = 1'b1;
      bus.button_n     = 1'b1;
      bus.sw_reset_req = 1'b0;
      model_reset();

      // Power-up
      repeat (5) cycle();
      check("por_out", bus.reset_out, 4'hF);
      check("por_ready", bus.ready, 0);
      reset_n = 1'b1;
      wait_released(CH, 200, "pwr_wait");
      check("pwr_out", bus.reset_out, 4'h0);
      check("pwr_ready", bus.ready, 1);
      check("pwr_restart", bus.restart_count, 0);

      // Lock loss in RUN
      bus.pll_locked = 1'b0;
      repeat (3) cycle();
      check("lock_loss_out", bus.reset_out, 4'hF);
      check("lock_loss_ready", bus.ready, 0);
      check("lock_loss_restart", bus.restart_count, 1);
      repeat (20) cycle();
      check("lock_low_out", bus.reset_out, 4'hF);
      bus.pll_locked = 1'b1;
      wait_released(CH, 100, "lock_back_wait");
      check("lock_back_ready", bus.ready, 1);

      // sw_reset_req exactly on the reset_out[1] release edge
      pulse_sw();
      check("sw_run_restart", bus.restart_count, 2);
      wait_released(1, 100, "sw_rel0_wait");
      check("sw_rel0_out", bus.reset_out, 4'hE);
      repeat (SD - 1) cycle();
      pulse_sw();
      check("sw_rel1_out", bus.reset_out, 4'hF);
      check("sw_rel1_restart", bus.restart_count, 3);

      // Lock glitch in ASSERT at hold_cnt=10
      k = 0;
      while (qual != 10 && k < 50) begin
         cycle();
         k++;
      end
      if (qual != 10) timeout("glitch_wait");
      bus.pll_locked = 1'b0;
      repeat (3) cycle();
      bus.pll_locked = 1'b1;
      repeat (SYNC + HOLD - 1) cycle();
      check("glitch_still_held", bus.reset_out, 4'hF);
      wait_released(CH, 100, "glitch_ready_wait");
      check("glitch_restart", bus.restart_count, 3);

      // Bouncy button, then held low, then released
      for (int i = 0; i < 200; i++) begin
         bus.button_n = ((i / 10) % 2 == 0) ? 1'b0 : 1'b1;
         cycle();
      end
      check("bounce_no_reset", bus.reset_out, 4'h0);
      bus.button_n = 1'b0;
      repeat (SYNC + DB - 1) cycle();
      check("press_not_yet", bus.reset_out, 4'h0);
      repeat (3) cycle();
      check("press_out", bus.reset_out, 4'hF);
      check("press_restart", bus.restart_count, 4);
      repeat (60) cycle();
      bus.button_n = 1'b1;
      repeat (40) cycle();
      check("release_held", bus.reset_out, 4'hF);
      wait_released(CH, 200, "button_ready_wait");
      check("button_restart", bus.restart_count, 4);

      // Random lock drops, button presses and software requests
      for (int seg = 0; seg < 40; seg++) begin
         kind = $urandom_range(0, 3);
         len  = $urandom_range(5, 120);
         for (int i = 0; i < len; i++) begin
            bus.pll_locked   = (kind == 1) ? ($urandom_range(0, 9) == 0) : 1'b1;
            bus.button_n     = (kind == 2) ? ($urandom_range(0, 19) == 0) : 1'b1;
            bus.sw_reset_req = (kind == 3) ? ($urandom_range(0, 29) == 0) : 1'b0;
            cycle();
         end
      end
      bus.pll_locked   = 1'b1;
      bus.button_n     = 1'b1;
      bus.sw_reset_req = 1'b0;
      wait_released(CH, 400, "random_settle");

      // Restart counter saturation
      for (int i = 0; i < 300; i++) begin
         k = 0;
         while (qual < HOLD && k < 100) begin
            cycle();
            k++;
         end
         pulse_sw();
      end
      check("sat_restart", bus.restart_count, 255);
      check("sat_out", bus.reset_out, 4'hF);

      // Asynchronous reset mid-SEQ
      wait_released(2, 100, "midseq_wait");
      check("midseq_out", bus.reset_out, 4'hC);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_out", bus.reset_out, 4'hF);
      check("async_ready", bus.ready, 0);
      check("async_restart", bus.restart_count, 0);
      model_reset();
      @(negedge clk);
      repeat (2) cycle();
      reset_n = 1'b1;
      wait_released(CH, 200, "final_wait");
      check("final_ready", bus.ready, 1);
      check("final_restart", bus.restart_count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
